// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/fa_cell.sv
// Single-bit full adder built from two half-adder stages and an OR on the carries.
module fa_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic sum,
    output logic co
);

    logic halfSum;
    logic halfCarry;
    logic secondCarry;

    assign halfSum     = x ^ y;
    assign halfCarry   = x & y;
    assign sum         = halfSum ^ ci;
    assign secondCarry = halfSum & ci;
    assign co          = halfCarry | secondCarry;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial unsigned adder: one full-add per cycle, LSB first, WIDTH cycles per sum.
// Optional signed-overflow output is enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             c
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] opA_q, opA_d;
    logic [WIDTH-1:0] opB_q, opB_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic sumBit;
    logic carryOut;

    fa_cell u_fa (
        .x  (opA_q[0]),
        .y  (opB_q[0]),
        .ci (carry_q),
        .sum(sumBit),
        .co (carryOut)
    );

    // The published sum is loaded on the final SHIFT edge so it is valid
    // throughout the DONE cycle and never exposes a partial result.
    always_comb begin
        state_d = state_q;
        opA_d   = opA_q;
        opB_d   = opB_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    opA_d   = a;
                    opB_d   = b;
                    res_d   = '0;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                opA_d   = opA_q >> 1;
                opB_d   = opB_q >> 1;
                res_d   = {sumBit, res_q[WIDTH-1:1]};
                carry_d = carryOut;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    sum_d   = {sumBit, res_q[WIDTH-1:1]};
                    cout_d  = carryOut;
`ifdef SERIAL_ADD_OVF_EN
                    ovf_d   = carry_q ^ carryOut;
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            opA_q   <= '0;
            opB_q   <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            opA_q   <= opA_d;
            opB_q   <= opB_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign s    = sum_q;
    assign c    = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits, legal range 2..32.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 a  input  WIDTH  operand A; captured on the accepted start.
REQ-006 b  input  WIDTH  operand B; captured on the accepted start.
REQ-007 busy  output  1  high in SHIFT and DONE; low in IDLE.
REQ-008 done  output  1  one-cycle pulse; result valid in that cycle.
REQ-009 s  output  WIDTH  sum; holds the last completed result until the next accepted start.
REQ-010 c  output  1  carry-out of the MSB; holds with s.

Function
REQ-011 FSM states: IDLE, SHIFT, DONE.
REQ-012 IDLE -> SHIFT on start=1; the edge that samples start is the accept edge.
- a and b are latched into shift registers.
- Running carry is cleared to 0.
- Bit counter is cleared to 0.
REQ-013 SHIFT edge behaviour:
- One bit-serial full-add of the operand LSBs and the running carry.
- Both operand registers shift right by one.
- Sum bit enters the result register at the MSB; the result register shifts right.
- Carry register updates; counter increments.
REQ-014 SHIFT -> DONE on the edge where counter = WIDTH-1, i.e. exactly WIDTH SHIFT cycles.
REQ-015 DONE state:
- done=1 for exactly one cycle; s and c are updated from the result and carry registers.
- DONE -> IDLE unconditionally.
REQ-016 Latency: done high during cycle WIDTH+1 after the accept edge; throughput is one addition per WIDTH+2 cycles.
REQ-017 start asserted in SHIFT or DONE is ignored, not queued; operand registers are unaffected.
REQ-018 s and c do not change outside the DONE cycle; partial sums are never visible on s.
REQ-019 Arithmetic: {c,s} = a + b, unsigned, modulo 2^(WIDTH+1); wrap-around occurs only via c.
REQ-020 The counter is $clog2(WIDTH) bits wide; it never exceeds WIDTH-1.

Reset
REQ-021 rst=1 at an edge forces state IDLE and busy=0, done=0, s=0, c=0; operand, carry and counter registers go to 0.
REQ-022 rst mid-SHIFT or in DONE aborts the operation; no done pulse follows and the partial result is discarded.
REQ-023 rst has priority over start when both are high at the same edge.

Configuration
REQ-024 Macro SERIAL_ADD_OVF_EN.
- Defined: adds output ovf (1 bit), the signed overflow, i.e. carry into MSB XOR carry out of MSB. ovf is captured in the MSB SHIFT cycle, updated and held with s and c, and reset to 0.
- Undefined: the ovf port and its logic are absent; all other behaviour is identical.

Structure
REQ-025 Package serial_add_pkg holds:
- The state enum type (IDLE, SHIFT, DONE).
- The default WIDTH constant.
REQ-026 One sub-module fa_cell (inputs x, y, ci; outputs sum, co) is built from two half-adder stages plus an OR. It is instantiated once and is the only adder logic in the block.

Verification
REQ-027 a=0x00, b=0x00, start -> done at cycle 9 after accept; s=0x00, c=0, busy high for 9 cycles.
REQ-028 a=0xFF, b=0x01 -> s=0x00, c=1; with SERIAL_ADD_OVF_EN, ovf=0.
REQ-029 a=0x7F, b=0x01 -> s=0x80, c=0; with SERIAL_ADD_OVF_EN, ovf=1.
REQ-030 a=0x35, b=0x4A accepted; start with a=0xFF, b=0xFF pulsed during SHIFT -> single done, s=0x7F, c=0; no second done.
REQ-031 Accept a=0xAA, b=0x55; assert rst at the 4th SHIFT cycle -> no done; s=0, c=0, busy=0; a new start afterwards computes correctly.
REQ-032 Back-to-back starts held high continuously -> one accept every 10 cycles and one done per addition; exhaustive random check of {c,s} against a+b for WIDTH=8 and WIDTH=3.
